// File: rtl/detector_borda_pkg.sv
// Shared mode encoding and edge-qualification helper for the multi-channel edge detector.
package detector_borda_pkg;

  localparam logic [1:0] MODO_OFF     = 2'b00;
  localparam logic [1:0] MODO_SUBIDA  = 2'b01;
  localparam logic [1:0] MODO_DESCIDA = 2'b10;
  localparam logic [1:0] MODO_AMBAS   = 2'b11;

  // True when a transition in the given direction is reportable under this mode.
  function automatic logic qualifica(input logic [1:0] modo, input logic subida);
    logic ok;
    ok = 1'b0;
    case (modo)
      MODO_SUBIDA:  ok = subida;
      MODO_DESCIDA: ok = ~subida;
      MODO_AMBAS:   ok = 1'b1;
      default:      ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/filtro_canal.sv
// One channel: input synchronizer, stability filter and registered level.
// aceita flags the cycle in which nivel is about to take the synced value.
module filtro_canal #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic entrada,
  output logic nivel,
  output logic aceita
);

  localparam int CW = (FILT_CYCLES > 0) ? $clog2(FILT_CYCLES + 1) : 1;

  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0]          count;
  logic                   synced;

  assign synced = sync[SYNC_STAGES-1];

  // The counter holds the number of settled mismatch cycles; a change is accepted
  // once it has seen FILT_CYCLES of them (immediately when FILT_CYCLES is 0).
  assign aceita = (synced != nivel) && (count == CW'(FILT_CYCLES));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync  <= '0;
      count <= '0;
      nivel <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], entrada};
      if (synced == nivel || aceita) begin
        count <= '0;
      end else begin
        count <= count + 1'b1;
      end
      if (aceita) begin
        nivel <= synced;
      end
    end
  end

endmodule

// File: rtl/detector_borda_multi.sv
// Multi-channel filtered edge detector with per-channel mode, sticky flag and
// optional saturating edge counters (define DETECTOR_BORDA_CONTAGEM_EN).
module detector_borda_multi
  import detector_borda_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_CH-1:0]     entrada,
  input  logic [2*N_CH-1:0]   modo,
  input  logic [N_CH-1:0]     limpa,
  output logic [N_CH-1:0]     nivel,
  output logic [N_CH-1:0]     pulso,
  output logic [N_CH-1:0]     pendente
`ifdef DETECTOR_BORDA_CONTAGEM_EN
  , output logic [N_CH*CNT_W-1:0] contagem
`endif
);

  if (N_CH < 1 || N_CH > 32) begin : g_bad_n_ch
    $error("N_CH out of range");
  end
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("SYNC_STAGES out of range");
  end
  if (FILT_CYCLES < 0 || CNT_W < 1) begin : g_bad_cfg
    $error("FILT_CYCLES or CNT_W out of range");
  end

  logic [N_CH-1:0] aceita;
  logic [N_CH-1:0] pulso_next;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_canal
    filtro_canal #(
      .SYNC_STAGES(SYNC_STAGES),
      .FILT_CYCLES(FILT_CYCLES)
    ) u_filtro (
      .clk    (clk),
      .rst    (rst),
      .entrada(entrada[gi]),
      .nivel  (nivel[gi]),
      .aceita (aceita[gi])
    );

    // Direction comes from the level before the update: low now means rising.
    assign pulso_next[gi] = aceita[gi] && qualifica(modo[2*gi +: 2], ~nivel[gi]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pulso    <= '0;
      pendente <= '0;
    end else begin
      pulso    <= pulso_next;
      pendente <= (pendente & ~limpa) | pulso;
    end
  end

`ifdef DETECTOR_BORDA_CONTAGEM_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      contagem <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        // A clear coinciding with a pulse still counts that pulse.
        if (pulso[i]) begin
          if (limpa[i]) begin
            contagem[i*CNT_W +: CNT_W] <= CNT_W'(1);
          end else if (contagem[i*CNT_W +: CNT_W] != CNT_MAX) begin
            contagem[i*CNT_W +: CNT_W] <= contagem[i*CNT_W +: CNT_W] + 1'b1;
          end
        end else if (limpa[i]) begin
          contagem[i*CNT_W +: CNT_W] <= '0;
        end
      end
    end
  end
`endif

endmodule
